// File: rtl/csr_writeback_stage.sv
// csr_writeback_stage: registered writeback with ECALL trap redirect/flush.
// Optional MEPC_CAPTURE_EN builds the exception-PC capture toward the CSR file.
module csr_writeback_stage #(
    parameter int          FLUSH_CYCLES = 3,
    parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [2:0]  in_csr_cmd,
    input  logic        in_rf_wen,
    input  logic [4:0]  in_rd_addr,
    input  logic [31:0] in_alu_out,
    input  logic [31:0] in_pc,
    input  logic [31:0] csr_rdata,
    input  logic [31:0] trap_vector,
    output logic        rf_wen,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        wb_branch_hazard,
    output logic [31:0] redirect_pc,
    output logic        mepc_wen,
    output logic [31:0] mepc_wdata
);

    localparam logic [2:0] CSR_X     = 3'd0;
    localparam logic [2:0] CSR_W     = 3'd1;
    localparam logic [2:0] CSR_S     = 3'd2;
    localparam logic [2:0] CSR_C     = 3'd3;
    localparam logic [2:0] CSR_ECALL = 3'd4;

    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] FLUSH = 1'b1;

    localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

    logic [0:0] state;
    logic [3:0] cnt;
    logic       accept;
    logic       is_ecall;
    logic       is_csr_rd;
    logic       do_write;
    logic       do_trap;
    logic [31:0] wb_data;

    // Decode the incoming command and qualify acceptance by state.
    always_comb begin
        accept    = in_valid && (state == RUN);
        is_ecall  = 1'b0;
        is_csr_rd = 1'b0;
        unique case (in_csr_cmd)
            CSR_W, CSR_S, CSR_C: is_csr_rd = 1'b1;
            CSR_ECALL:           is_ecall  = 1'b1;
            default:             ;
        endcase
        do_trap  = accept && is_ecall;
        do_write = accept && !is_ecall && in_rf_wen
                   && (in_rd_addr != 5'd0);
        wb_data  = is_csr_rd ? csr_rdata : in_alu_out;
    end

    // Trap FSM: hold the hazard for FLUSH_CYCLES cycles after an ECALL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= RUN;
            cnt              <= 4'd0;
            wb_branch_hazard <= 1'b0;
            redirect_pc      <= RESET_PC;
        end else if (state == RUN) begin
            if (do_trap) begin
                state            <= FLUSH;
                cnt              <= CNT_INIT;
                wb_branch_hazard <= 1'b1;
                redirect_pc      <= trap_vector;
            end
        end else begin
            if (cnt == 4'd0) begin
                state            <= RUN;
                wb_branch_hazard <= 1'b0;
            end else begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // Register-file write port; data and address hold between writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_wen   <= 1'b0;
            rf_waddr <= 5'd0;
            rf_wdata <= 32'd0;
        end else begin
            rf_wen <= do_write;
            if (do_write) begin
                rf_waddr <= in_rd_addr;
                rf_wdata <= wb_data;
            end
        end
    end

`ifdef MEPC_CAPTURE_EN
    // One-cycle exception-PC capture pulse on trap entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mepc_wen   <= 1'b0;
            mepc_wdata <= 32'd0;
        end else begin
            mepc_wen <= do_trap;
            if (do_trap) begin
                mepc_wdata <= in_pc;
            end
        end
    end
`else
    assign mepc_wen   = 1'b0;
    assign mepc_wdata = 32'd0;

    logic unused_pc;
    assign unused_pc = ^in_pc;
`endif

endmodule

// File: tb/tb_csr_writeback_stage.sv
// tb_csr_writeback_stage: directed + random checks against a
// cycle-level behavioural model of the writeback/trap rules.
module tb_csr_writeback_stage;

    localparam int          FC   = 3;
    localparam logic [31:0] RPC  = 32'hDEAD_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [2:0]  in_csr_cmd = 3'd0;
    logic        in_rf_wen = 1'b0;
    logic [4:0]  in_rd_addr = 5'd0;
    logic [31:0] in_alu_out = 32'd0;
    logic [31:0] in_pc = 32'd0;
    logic [31:0] csr_rdata = 32'd0;
    logic [31:0] trap_vector = 32'd0;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        wb_branch_hazard;
    logic [31:0] redirect_pc;
    logic        mepc_wen;
    logic [31:0] mepc_wdata;

    int checks = 0;
    int errors = 0;

    logic        e_wen;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic        e_haz;
    logic [31:0] e_pc;
    logic        e_mwen;
    logic [31:0] e_mdata;
    int          rem;

    csr_writeback_stage #(
        .FLUSH_CYCLES(FC),
        .RESET_PC(RPC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_csr_cmd(in_csr_cmd),
        .in_rf_wen(in_rf_wen),
        .in_rd_addr(in_rd_addr),
        .in_alu_out(in_alu_out),
        .in_pc(in_pc),
        .csr_rdata(csr_rdata),
        .trap_vector(trap_vector),
        .rf_wen(rf_wen),
        .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata),
        .wb_branch_hazard(wb_branch_hazard),
        .redirect_pc(redirect_pc),
        .mepc_wen(mepc_wen),
        .mepc_wdata(mepc_wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h @%0t", nm, act, exp,
                     $time);
        end
    endtask

    task automatic model_reset();
        e_wen = 0; e_waddr = 0; e_wdata = 0; e_haz = 0;
        e_pc = RPC; e_mwen = 0; e_mdata = 0; rem = 0;
    endtask

    // Next-cycle outputs from the current inputs.
    task automatic model_step();
        e_wen  = 0;
        e_mwen = 0;
        if (e_haz) begin
            rem   = rem - 1;
            e_haz = (rem > 0);
        end else if (in_valid) begin
            if (in_csr_cmd == 3'd4) begin
                rem   = FC;
                e_haz = 1;
                e_pc  = trap_vector;
`ifdef MEPC_CAPTURE_EN
                e_mwen  = 1;
                e_mdata = in_pc;
`endif
            end else if (in_rf_wen && in_rd_addr != 0) begin
                e_wen   = 1;
                e_waddr = in_rd_addr;
                e_wdata = (in_csr_cmd >= 3'd1 && in_csr_cmd <= 3'd3)
                          ? csr_rdata : in_alu_out;
            end
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] cmd,
                         input logic w, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] cd,
                         input logic [31:0] tv, input logic [31:0] pc);
        in_valid = v; in_csr_cmd = cmd; in_rf_wen = w;
        in_rd_addr = rd; in_alu_out = alu; csr_rdata = cd;
        trap_vector = tv; in_pc = pc;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic async_reset(input string nm);
        rst = 1'b1;
        #1;
        model_reset();
        chk({nm, "_wen"}, 32'(rf_wen), 0);
        chk({nm, "_waddr"}, 32'(rf_waddr), 0);
        chk({nm, "_wdata"}, rf_wdata, 0);
        chk({nm, "_haz"}, 32'(wb_branch_hazard), 0);
        chk({nm, "_pc"}, redirect_pc, RPC);
        chk({nm, "_mwen"}, 32'(mepc_wen), 0);
        chk({nm, "_mdata"}, mepc_wdata, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("m_wen", 32'(rf_wen), 32'(e_wen));
            chk("m_waddr", 32'(rf_waddr), 32'(e_waddr));
            chk("m_wdata", rf_wdata, e_wdata);
            chk("m_haz", 32'(wb_branch_hazard), 32'(e_haz));
            chk("m_pc", redirect_pc, e_pc);
            chk("m_mwen", 32'(mepc_wen), 32'(e_mwen));
            chk("m_mdata", mepc_wdata, e_mdata);
        end
    end

    initial begin
        #100000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        async_reset("rst0");

        drive(1, 3'd2, 1, 5, 32'hFFFF, 32'h0000_00AB, 0, 0);
        step();
        idle();
        chk("csr_s_wen", 32'(rf_wen), 1);
        chk("csr_s_waddr", 32'(rf_waddr), 5);
        chk("csr_s_wdata", rf_wdata, 32'hAB);

        drive(1, 3'd0, 1, 0, 32'h1234, 32'h0, 0, 0);
        step();
        idle();
        chk("x0_wen", 32'(rf_wen), 0);
        chk("x0_hold", rf_wdata, 32'hAB);

        drive(1, 3'd4, 0, 0, 0, 0, 32'h100, 32'h40);
        step();
        idle();
        chk("ec_haz1", 32'(wb_branch_hazard), 1);
        chk("ec_pc1", redirect_pc, 32'h100);
        chk("ec_wen1", 32'(rf_wen), 0);
`ifdef MEPC_CAPTURE_EN
        chk("ec_mwen1", 32'(mepc_wen), 1);
        chk("ec_mdata1", mepc_wdata, 32'h40);
`else
        chk("ec_mwen1", 32'(mepc_wen), 0);
`endif
        step();
        chk("ec_haz2", 32'(wb_branch_hazard), 1);
        chk("ec_mwen2", 32'(mepc_wen), 0);
        step();
        chk("ec_haz3", 32'(wb_branch_hazard), 1);
        chk("ec_pc3", redirect_pc, 32'h100);
        step();
        chk("ec_haz4", 32'(wb_branch_hazard), 0);

        drive(1, 3'd4, 0, 0, 0, 0, 32'h200, 32'h80);
        step();
        idle();
        step();
        drive(1, 3'd4, 1, 3, 32'h77, 32'h77, 32'h300, 32'hC0);
        step();
        idle();
        chk("re_haz3", 32'(wb_branch_hazard), 1);
        chk("re_pc3", redirect_pc, 32'h200);
        chk("re_wen3", 32'(rf_wen), 0);
        chk("re_mwen3", 32'(mepc_wen), 0);
        step();
        chk("re_haz4", 32'(wb_branch_hazard), 0);
        step();
        chk("re_haz5", 32'(wb_branch_hazard), 0);

        drive(1, 3'd4, 0, 0, 0, 0, 32'h400, 32'h10);
        step();
        idle();
        step();
        async_reset("rstfl");
        chk("rstfl_haz_after", 32'(wb_branch_hazard), 0);
        drive(1, 3'd1, 1, 7, 32'h0, 32'h55, 0, 0);
        step();
        idle();
        chk("post_rst_wen", 32'(rf_wen), 1);
        chk("post_rst_waddr", 32'(rf_waddr), 7);
        chk("post_rst_wdata", rf_wdata, 32'h55);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                async_reset("rnd_rst");
            end
            drive($urandom_range(0, 3) != 0,
                  ($urandom_range(0, 9) == 0) ? 3'd4
                      : 3'($urandom_range(0, 7)),
                  $urandom_range(0, 3) != 0,
                  ($urandom_range(0, 7) == 0) ? 5'd0
                      : 5'($urandom),
                  $urandom, $urandom, $urandom, $urandom);
            step();
        end
        idle();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
